mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Shares one 4:1 data mux between four requesters using round-robin arbitration with packet locking.
//  A grant is held from a requester's first beat until its last beat, or until the requester stalls
//  beyond a timeout. Sits upstream of a single shared consumer, e.g. a link or FIFO, and drives the mux select.
// PARAMETERS
//  DATA_W        8    width of one requester data lane and of out_data
//  IDLE_TIMEOUT  16   cycles of req low while locked before forced release; 0 = never release
// PORTS
//  clk        in   1          single clock; all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  req_i      in   4          per-requester valid; bit i = requester i
//  last_i     in   4          per-requester end-of-packet marker, qualified by req_i
//  data_i     in   4*DATA_W   lane i at [i*DATA_W +: DATA_W]
//  ready_o    out  4          per-requester ready; at most one bit set
//  out_valid  out  1          shared output valid
//  out_ready  in   1          shared output ready from consumer
//  out_data   out  DATA_W     muxed data = lane sel_o
//  out_last   out  1          muxed last_i[sel_o]
//  grant_o    out  4          one-hot current grant; 0 when idle
//  sel_o      out  2          registered mux select; holds last value when idle
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, sel_o=0, grant_o=0, stall_cnt=0.
//  Outputs during reset: out_valid=0, ready_o=0. out_data=lane 0, because out_data follows sel_o.
//  States: IDLE, LOCK.
//  IDLE:
//   - out_valid=0 and ready_o=0.
//   - If req_i!=0: winner = first i with req_i[i]=1, scanning ptr, ptr+1, ... mod 4.
//   - Next edge: sel_o=winner, grant_o=1<<winner, state=LOCK.
//   - Arbitration latency is 1 cycle; no data is transferred in IDLE.
//  LOCK (g = sel_o):
//   - out_valid=req_i[g]; out_data=data lane g; out_last=last_i[g].
//   - ready_o[g]=out_ready; all other ready_o bits are 0.
//   - beat = out_valid & out_ready.
//   - beat & last_i[g]: next edge state=IDLE, grant_o=0, ptr=g+1 mod 4, stall_cnt=0.
//   - beat & !last_i[g]: stay in LOCK, stall_cnt=0.
//   - req_i[g]=0: stall_cnt+=1. If IDLE_TIMEOUT!=0 and stall_cnt==IDLE_TIMEOUT-1:
//     release next edge (IDLE, grant_o=0, ptr=g+1 mod 4, stall_cnt=0).
//   - req_i[g]=1 with out_ready=0: backpressure, not a stall; stall_cnt holds.
//   - Other requesters' req_i and last_i are ignored while locked.
//  Boundaries:
//   - Single-beat packet (last with first beat): LOCK lasts one cycle; then 1 IDLE bubble cycle.
//   - ptr wraps 3->0. All four requesting continuously gives grant order 0,1,2,3,0,...
//   - Only the current holder requesting again: it is re-granted after the bubble.
//   - rst during LOCK: immediate return to reset values; the in-flight packet is truncated, no last emitted.
//   - stall_cnt width: $clog2(IDLE_TIMEOUT+1); it saturates and never wraps.
//  No combinational path from req_i to grant_o or sel_o (both registered).
//  Combinational paths exist only from out_ready to ready_o and from data_i/req_i/last_i to out_*.
// STRUCTURE
//  Package mux4_arb_pkg:
//   - localparam N_REQ=4, SEL_W=2
//   - typedef enum logic {IDLE, LOCK} arb_state_t
//  Sub-module rr_pick4: combinational; inputs req[3:0], ptr[1:0]; outputs any, idx[1:0].
//  Top holds: FSM, ptr, stall counter, the shared data mux (case on sel_o), ready demux.
// TESTING
//  1. rst=1 for 3 cycles, arbitrary req_i -> grant_o=0, out_valid=0, ready_o=0, sel_o=0.
//  2. req_i=4'b0100, 3-beat packet, out_ready=1 ->
//     grant_o=4'b0100 one cycle after req, beats on 3 consecutive cycles, then IDLE, ptr=3.
//  3. req_i=4'b1111, single-beat packets, out_ready=1 ->
//     grants 0,1,2,3,0 with one IDLE cycle between each.
//  4. Requester 1 locked, out_ready=0 for 10 cycles -> ready_o=0, no release, data held.
//     Then out_ready=1 -> beat completes.
//  5. IDLE_TIMEOUT=4, requester 2 locked, req_i[2] drops ->
//     release after exactly 4 stall cycles; next requester 3 gets the grant.
//  6. rst asserted mid-packet (beat 2 of 5) ->
//     next cycle all reset values; after rst is released, requester 0 is granted first.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
// Imported by the pick logic and the arbiter top.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    LOCK
  } arb_state_t;

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Round-robin winner search over four requests.
// The search starts at ptr and wraps modulo 4.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;

  assign any = |req;

  // Walk from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    idx    = ptr;
    w_cand = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = ptr + SEL_W'(k);
      if (req[w_cand]) idx = w_cand;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester shared 4:1 mux with round-robin grant and packet lock.
// The grant holds until a last beat or until the holder idles past the timeout.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        last_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        ready_o,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [N_REQ-1:0]        grant_o,
  output logic [SEL_W-1:0]        sel_o
);

  localparam int CW =
    (IDLE_TIMEOUT == 0) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam int TO_M1 =
    (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;
  localparam logic [CW-1:0] STALL_MAX = '1;
  localparam logic [CW-1:0] STALL_REL = CW'(TO_M1);

  arb_state_t       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [N_REQ-1:0] r_grant;
  logic [CW-1:0]    r_stall;

  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic             w_lock;
  logic             w_req_g;
  logic             w_last_g;
  logic             w_beat;
  logic             w_timeout;

  rr_pick4 u_pick (
    .req (req_i),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign w_lock    = (r_state == LOCK);
  assign w_req_g   = req_i[r_sel];
  assign w_last_g  = last_i[r_sel];
  assign out_valid = w_lock & w_req_g;
  assign w_beat    = out_valid & out_ready;
  assign out_last  = w_last_g;
  assign grant_o   = r_grant;
  assign sel_o     = r_sel;

  assign w_timeout = (IDLE_TIMEOUT != 0) && w_lock &&
                     !w_req_g && (r_stall == STALL_REL);

  always_comb begin
    ready_o = '0;
    if (w_lock) ready_o[r_sel] = out_ready;
  end

  always_comb begin
    out_data = '0;
    unique case (r_sel)
      2'd0: out_data = data_i[0*DATA_W +: DATA_W];
      2'd1: out_data = data_i[1*DATA_W +: DATA_W];
      2'd2: out_data = data_i[2*DATA_W +: DATA_W];
      2'd3: out_data = data_i[3*DATA_W +: DATA_W];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_stall <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel   <= w_idx;
            r_grant <= 4'b0001 << w_idx;
            r_state <= LOCK;
            r_stall <= '0;
          end
        end
        LOCK: begin
          if ((w_beat && w_last_g) || w_timeout) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= r_sel + SEL_W'(1);
            r_stall <= '0;
          end else if (w_beat) begin
            r_stall <= '0;
          end else if (!w_req_g && r_stall != STALL_MAX) begin
            // Backpressure with req held is not idling.
            r_stall <= r_stall + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, packets, rotation,
// backpressure, idle release and reset mid-packet.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_i;
  logic [3:0]  last_i;
  logic [31:0] data_i;
  logic [3:0]  ready_o;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  grant_o;
  logic [1:0]  sel_o;

  int checks;
  int failures;

  logic [10:0] obs;
  logic [10:0] exp_st;

  mux4_rr_arbiter #(
    .DATA_W       (8),
    .IDLE_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .last_i    (last_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .grant_o   (grant_o),
    .sel_o     (sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {grant, sel, valid, ready}.
  function automatic logic [10:0] st(
    input logic [3:0] g,
    input logic [1:0] s,
    input logic       v,
    input logic [3:0] r
  );
    return {g, s, v, r};
  endfunction

  task automatic test_reset();
    rst       = 1'b1;
    req_i     = 4'b1011;
    last_i    = 4'b1111;
    data_i    = 32'h44332211;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      obs = {grant_o, sel_o, out_valid, ready_o};
      exp_st = '0;
      checks++;
      if (obs !== exp_st) begin
        failures++;
        $display("FAIL reset_state got=%h exp=%h", obs, exp_st);
      end
      checks++;
      if (out_data !== 8'h11) begin
        failures++;
        $display("FAIL reset_data got=%h exp=11", out_data);
      end
    end
  endtask

  task automatic test_packet();
    @(negedge clk);
    rst    = 1'b0;
    req_i  = 4'b0100;
    last_i = 4'b0000;
    data_i = 32'h00A00000;
    #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    checks++;
    if (obs !== st(4'b0, 2'd0, 1'b0, 4'b0)) begin
      failures++;
      $display("FAIL pkt_idle got=%h", obs);
    end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      data_i[23:16] = 8'hA0 + 8'(b);
      last_i[2]     = (b == 2);
      #1;
      obs = {grant_o, sel_o, out_valid, ready_o};
      exp_st = st(4'b0100, 2'd2, 1'b1, 4'b0100);
      checks++;
      if (obs !== exp_st) begin
        failures++;
        $display("FAIL pkt_beat%0d got=%h exp=%h", b, obs, exp_st);
      end
      checks++;
      if ({out_data, out_last} !== {8'hA0 + 8'(b), b == 2}) begin
        failures++;
        $display("FAIL pkt_data%0d got=%h/%b", b, out_data, out_last);
      end
    end
    // ptr must now be 3: requester 3 beats requester 0.
    @(negedge clk);
    req_i  = 4'b1001;
    last_i = 4'b1001;
    data_i = 32'h33000011;
    #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    exp_st = st(4'b0, 2'd2, 1'b0, 4'b0);
    checks++;
    if (obs !== exp_st) begin
      failures++;
      $display("FAIL pkt_release got=%h exp=%h", obs, exp_st);
    end
    @(negedge clk); #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    exp_st = st(4'b1000, 2'd3, 1'b1, 4'b1000);
    checks++;
    if (obs !== exp_st || out_data !== 8'h33) begin
      failures++;
      $display("FAIL ptr_after_pkt got=%h/%h exp=%h/33",
               obs, out_data, exp_st);
    end
  endtask

  task automatic test_rr();
    logic [1:0] e;
    @(negedge clk);
    req_i  = 4'b1111;
    last_i = 4'b1111;
    data_i = 32'h33221100;
    #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    checks++;
    if (obs !== st(4'b0, 2'd3, 1'b0, 4'b0)) begin
      failures++;
      $display("FAIL rr_idle0 got=%h", obs);
    end
    for (int k = 0; k < 5; k++) begin
      e = 2'(k % 4);
      @(negedge clk); #1;
      obs = {grant_o, sel_o, out_valid, ready_o};
      exp_st = st(4'b0001 << e, e, 1'b1, 4'b0001 << e);
      checks++;
      if (obs !== exp_st || out_data !== {2'b0, e, 2'b0, e}) begin
        failures++;
        $display("FAIL rr_grant%0d got=%h/%h exp=%h",
                 k, obs, out_data, exp_st);
      end
      @(negedge clk);
      if (k == 4) req_i = 4'b0;
      #1;
      obs = {grant_o, sel_o, out_valid, ready_o};
      exp_st = st(4'b0, e, 1'b0, 4'b0);
      checks++;
      if (obs !== exp_st) begin
        failures++;
        $display("FAIL rr_bubble%0d got=%h exp=%h", k, obs, exp_st);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_i     = 4'b0010;
    last_i    = 4'b0000;
    data_i    = 32'h00005A00;
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      obs = {grant_o, sel_o, out_valid, ready_o};
      exp_st = st(4'b0010, 2'd1, 1'b1, 4'b0);
      checks++;
      if (obs !== exp_st || out_data !== 8'h5A) begin
        failures++;
        $display("FAIL bp_hold%0d got=%h/%h exp=%h/5a",
                 c, obs, out_data, exp_st);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    last_i    = 4'b0010;
    #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    exp_st = st(4'b0010, 2'd1, 1'b1, 4'b0010);
    checks++;
    if (obs !== exp_st || out_last !== 1'b1) begin
      failures++;
      $display("FAIL bp_beat got=%h/%b exp=%h/1", obs, out_last, exp_st);
    end
    @(negedge clk);
    req_i  = 4'b0;
    last_i = 4'b0;
    #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    checks++;
    if (obs !== st(4'b0, 2'd1, 1'b0, 4'b0)) begin
      failures++;
      $display("FAIL bp_done got=%h", obs);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    req_i  = 4'b0100;
    last_i = 4'b0000;
    data_i = 32'h00C10000;
    #1;
    @(negedge clk); #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    exp_st = st(4'b0100, 2'd2, 1'b1, 4'b0100);
    checks++;
    if (obs !== exp_st) begin
      failures++;
      $display("FAIL to_lock got=%h exp=%h", obs, exp_st);
    end
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      req_i = 4'b1000;
      #1;
      obs = {grant_o, sel_o, out_valid, ready_o};
      exp_st = st(4'b0100, 2'd2, 1'b0, 4'b0100);
      checks++;
      if (obs !== exp_st) begin
        failures++;
        $display("FAIL to_stall%0d got=%h exp=%h", s, obs, exp_st);
      end
    end
    @(negedge clk); #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    checks++;
    if (obs !== st(4'b0, 2'd2, 1'b0, 4'b0)) begin
      failures++;
      $display("FAIL to_release got=%h", obs);
    end
    @(negedge clk);
    last_i = 4'b1000;
    #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    exp_st = st(4'b1000, 2'd3, 1'b1, 4'b1000);
    checks++;
    if (obs !== exp_st) begin
      failures++;
      $display("FAIL to_next got=%h exp=%h", obs, exp_st);
    end
    @(negedge clk);
    req_i  = 4'b0;
    last_i = 4'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_i  = 4'b0010;
    last_i = 4'b0010;
    #1;
    @(negedge clk); #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    exp_st = st(4'b0010, 2'd1, 1'b1, 4'b0010);
    checks++;
    if (obs !== exp_st) begin
      failures++;
      $display("FAIL rm_pre got=%h exp=%h", obs, exp_st);
    end
    @(negedge clk);
    req_i  = 4'b0100;
    last_i = 4'b0000;
    data_i = 32'h00D00000;
    #1;
    @(negedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    exp_st = st(4'b0100, 2'd2, 1'b1, 4'b0100);
    checks++;
    if (obs !== exp_st || out_data !== 8'hD0) begin
      failures++;
      $display("FAIL rm_beat2 got=%h/%h exp=%h/d0", obs, out_data, exp_st);
    end
    @(negedge clk);
    rst    = 1'b0;
    req_i  = 4'b1111;
    last_i = 4'b1111;
    data_i = 32'h33221100;
    #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    checks++;
    if (obs !== st(4'b0, 2'd0, 1'b0, 4'b0) || out_data !== 8'h00) begin
      failures++;
      $display("FAIL rm_reset got=%h/%h", obs, out_data);
    end
    @(negedge clk); #1;
    obs = {grant_o, sel_o, out_valid, ready_o};
    exp_st = st(4'b0001, 2'd0, 1'b1, 4'b0001);
    checks++;
    if (obs !== exp_st) begin
      failures++;
      $display("FAIL rm_first got=%h exp=%h", obs, exp_st);
    end
    @(negedge clk);
    req_i  = 4'b0;
    last_i = 4'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_packet();
    test_rr();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
